// File: rtl/decoder_line_encoder_pkg.sv
// Shared types and helpers for the line re-encoder and its priority encoder.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int code_width(input int n);
    return $clog2(n);
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/decoder_line_encoder_lsb_prio_enc.sv
// Combinational lowest-set-bit encoder with an any-set flag.
module lsb_prio_enc
  import decoder_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = code_width(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] code,
  output logic         any
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) code = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/decoder_line_encoder.sv
// Captures a request vector and streams the index of each set line, lowest first.
module decoder_line_encoder
  import decoder_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = code_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         out_none,
  output logic         busy
);

  // state | meaning
  // IDLE  | ready to capture a new vector
  // EMIT  | streaming codes of pending, one per accepted handshake

  state_t       state, state_nxt;
  logic [N-1:0] pending, pending_nxt;
  logic         none_nxt;
  logic         pending_any;

  lsb_prio_enc #(.N(N)) u_enc (
    .vec  (pending),
    .code (out_code),
    .any  (pending_any)
  );

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_last  = is_onehot(32'(pending));

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    none_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (in_vec != '0) begin
            pending_nxt = in_vec;
            state_nxt   = EMIT;
          end else begin
            none_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        // Clearing the lowest set bit retires exactly the code on out_code.
        if (out_ready) begin
          pending_nxt = pending & (pending - N'(1));
          if (out_last || !pending_any) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      out_none <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      out_none <= none_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_line_encoder.sv
// Directed, table-driven bench for decoder_line_encoder (N=4).
module tb_decoder_line_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_code;
  logic       out_last;
  logic       out_none;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_line_encoder #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_none  (out_none),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0]      vec;
    logic            toggle;  // out_ready alternates 1,0,1,0...
    logic            noise;   // hold in_valid=1, in_vec=1000 during EMIT
    int              n;
    logic [3:0][1:0] codes;   // codes[k] is the k-th expected code
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int         k;
    int         j;
    logic       stalled;
    logic [1:0] held;
    logic       done;
    @(negedge clk);
    check("pre_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_vec    = t.vec;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = t.noise;
    in_vec   = t.noise ? 4'b1000 : 4'b0000;
    k = 0; stalled = 1'b0; held = '0; done = 1'b0;
    for (j = 0; j < 20 && !done; j++) begin
      if (!out_valid) begin
        in_valid = 1'b0;
        check("code_count", k, t.n);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        done = 1'b1;
      end else begin
        check("busy_in_emit", busy, 1);
        check("in_ready_in_emit", in_ready, 0);
        if (stalled) check("stall_code_stable", out_code, held);
        out_ready = t.toggle ? (j % 2 == 0) : 1'b1;
        if (out_ready) begin
          if (k < t.n) begin
            check("code", out_code, t.codes[k]);
            check("last", out_last, (k == t.n - 1));
          end else begin
            check("extra_code", k, t.n);
          end
          k++;
        end
        stalled = !out_ready;
        held    = out_code;
        @(negedge clk);
      end
    end
    if (!done) check("emit_timeout", 0, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{vec: 4'b0001, toggle: 1'b0, noise: 1'b0, n: 1, codes: {2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[1] = '{vec: 4'b1010, toggle: 1'b0, noise: 1'b0, n: 2, codes: {2'd0, 2'd0, 2'd3, 2'd1}};
    tbl[2] = '{vec: 4'b1111, toggle: 1'b1, noise: 1'b0, n: 4, codes: {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[3] = '{vec: 4'b0110, toggle: 1'b0, noise: 1'b1, n: 2, codes: {2'd0, 2'd0, 2'd2, 2'd1}};
    tbl[4] = '{vec: 4'b1001, toggle: 1'b1, noise: 1'b0, n: 2, codes: {2'd0, 2'd0, 2'd3, 2'd0}};
    tbl[5] = '{vec: 4'b1000, toggle: 1'b0, noise: 1'b0, n: 1, codes: {2'd0, 2'd0, 2'd0, 2'd3}};

    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_none", out_none, 0);
    check("rst_out_code", out_code, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // All-zero vector: one-cycle out_none, no output
    @(negedge clk);
    in_valid = 1'b1; in_vec = 4'b0000;
    @(negedge clk);
    in_valid = 1'b0;
    check("none_pulse", out_none, 1);
    check("none_out_valid", out_valid, 0);
    check("none_in_ready", in_ready, 1);
    @(negedge clk);
    check("none_pulse_end", out_none, 0);
    check("none_out_valid2", out_valid, 0);

    // Reset after the first code of 1100: code 3 must never come out
    in_valid = 1'b1; in_vec = 4'b1100;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_code0", out_code, 2);
    check("rst_mid_valid0", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_code1", out_code, 3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_code", out_code, 0);
    check("rst_mid_last", out_last, 0);
    rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    run_vec(tbl[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
